alu_exec_unit: RTL

Integer execution unit at the issue end of the reservation station. It accepts one ready RV32I ALU, branch or jump op per cycle and computes the result, branch outcome and target. Completed results are queued in a small result FIFO and broadcast on the ALU common data bus, with hold-until-grant back-pressure. It sits between the RS issue port and the CDB arbiter that feeds RS, LSB and ROB.

---
 rtl/alu_exec_unit.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// Integer execution unit: computes RV32I ALU/branch/jump results and queues them
// in a small result FIFO that broadcasts on the ALU CDB with hold-until-grant.
module alu_exec_unit #(
   parameter int DATA_W = 32,
   parameter int ROB_W  = 4,
   parameter int OP_W   = 6,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              clr,
   input  logic              in_valid,
   input  logic [OP_W-1:0]   in_op,
   input  logic [DATA_W-1:0] in_rs1_value,
   input  logic [DATA_W-1:0] in_rs2_value,
   input  logic [DATA_W-1:0] in_imm,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [ROB_W-1:0]  in_rd_rename,
   output logic              alu_full,
   input  logic              cdb_grant,
   output logic              alu_broadcast,
   output logic [DATA_W-1:0] alu_cbd_value,
   output logic [ROB_W-1:0]  alu_update_rename,
   output logic              alu_branch_taken,
   output logic [DATA_W-1:0] alu_target_pc,
   output logic              alu_drop
);

   localparam logic [OP_W-1:0] OP_LUI   = OP_W'(1);
   localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(2);
   localparam logic [OP_W-1:0] OP_JAL   = OP_W'(3);
   localparam logic [OP_W-1:0] OP_JALR  = OP_W'(4);
   localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5);
   localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);
   localparam logic [OP_W-1:0] OP_BLT   = OP_W'(7);
   localparam logic [OP_W-1:0] OP_BGE   = OP_W'(8);
   localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(9);
   localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(10);
   localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(11);
   localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(12);
   localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(13);
   localparam logic [OP_W-1:0] OP_XORI  = OP_W'(14);
   localparam logic [OP_W-1:0] OP_ORI   = OP_W'(15);
   localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(16);
   localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(17);
   localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(18);
   localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(19);
   localparam logic [OP_W-1:0] OP_ADD   = OP_W'(20);
   localparam logic [OP_W-1:0] OP_SUB   = OP_W'(21);
   localparam logic [OP_W-1:0] OP_SLL   = OP_W'(22);
   localparam logic [OP_W-1:0] OP_SLT   = OP_W'(23);
   localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(24);
   localparam logic [OP_W-1:0] OP_XOR   = OP_W'(25);
   localparam logic [OP_W-1:0] OP_SRL   = OP_W'(26);
   localparam logic [OP_W-1:0] OP_SRA   = OP_W'(27);
   localparam logic [OP_W-1:0] OP_OR    = OP_W'(28);
   localparam logic [OP_W-1:0] OP_AND   = OP_W'(29);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_W-1:0]        op2;
   logic signed [DATA_W-1:0] s_rs1;
   logic signed [DATA_W-1:0] s_op2;
   logic [4:0]               shamt;
   logic [DATA_W-1:0]        pc_plus4;
   logic [DATA_W-1:0]        pc_plus_imm;
   logic                     br_cond;
   logic                     is_branch;
   logic [DATA_W-1:0]        res_value;
   logic                     res_taken;
   logic [DATA_W-1:0]        res_target;

   always_comb begin
      case (in_op)
         OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
         OP_SLLI, OP_SRLI, OP_SRAI: op2 = in_imm;
         default:                   op2 = in_rs2_value;
      endcase
   end

   assign s_rs1       = in_rs1_value;
   assign s_op2       = op2;
   assign shamt       = op2[4:0];
   assign pc_plus4    = in_pc + DATA_W'(4);
   assign pc_plus_imm = in_pc + in_imm;

   always_comb begin
      br_cond   = 1'b0;
      is_branch = 1'b1;
      case (in_op)
         OP_BEQ:  br_cond = (in_rs1_value == op2);
         OP_BNE:  br_cond = (in_rs1_value != op2);
         OP_BLT:  br_cond = (s_rs1 < s_op2);
         OP_BGE:  br_cond = (s_rs1 >= s_op2);
         OP_BLTU: br_cond = (in_rs1_value < op2);
         OP_BGEU: br_cond = (in_rs1_value >= op2);
         default: is_branch = 1'b0;
      endcase
   end

   // Result compute: value / taken / target for the op at the issue port
   always_comb begin
      res_value  = '0;
      res_taken  = 1'b0;
      res_target = pc_plus4;
      case (in_op)
         OP_ADD, OP_ADDI:   res_value = in_rs1_value + op2;
         OP_SUB:            res_value = in_rs1_value - op2;
         OP_SLL, OP_SLLI:   res_value = in_rs1_value << shamt;
         OP_SRL, OP_SRLI:   res_value = in_rs1_value >> shamt;
         OP_SRA, OP_SRAI:   res_value = s_rs1 >>> shamt;
         OP_SLT, OP_SLTI:   res_value[0] = (s_rs1 < s_op2);
         OP_SLTU, OP_SLTIU: res_value[0] = (in_rs1_value < op2);
         OP_XOR, OP_XORI:   res_value = in_rs1_value ^ op2;
         OP_OR, OP_ORI:     res_value = in_rs1_value | op2;
         OP_AND, OP_ANDI:   res_value = in_rs1_value & op2;
         OP_LUI:            res_value = in_imm;
         OP_AUIPC:          res_value = pc_plus_imm;
         OP_JAL: begin
            res_value  = pc_plus4;
            res_taken  = 1'b1;
            res_target = pc_plus_imm;
         end
         OP_JALR: begin
            res_value  = pc_plus4;
            res_taken  = 1'b1;
            res_target = (in_rs1_value + in_imm) & ~DATA_W'(1);
         end
         default: begin
            if (is_branch) begin
               res_taken  = br_cond;
               res_target = br_cond ? pc_plus_imm : pc_plus4;
            end
         end
      endcase
   end

   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic              drop_q, drop_d;
   logic [DATA_W-1:0] value_mem_q  [DEPTH];
   logic [ROB_W-1:0]  tag_mem_q    [DEPTH];
   logic              taken_mem_q  [DEPTH];
   logic [DATA_W-1:0] target_mem_q [DEPTH];
   logic              fifo_full;
   logic              pop;
   logic              push;

   assign fifo_full = (count_q == FULL_CNT);
   assign pop       = rdy & ~clr & alu_broadcast & cdb_grant;
   // A full FIFO still accepts an issue when the head leaves in the same cycle
   assign push      = rdy & ~clr & in_valid & (~fifo_full | pop);

   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      drop_d  = drop_q;
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      if (push & ~pop)      count_d = count_q + 1'b1;
      else if (pop & ~push) count_d = count_q - 1'b1;
      if (rdy & in_valid & fifo_full & ~pop) drop_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst | clr) begin
         count_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         drop_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         drop_q  <= drop_d;
      end
   end

   // Entry storage carries no reset; outputs are gated while the FIFO is empty
   always_ff @(posedge clk) begin
      if (push & ~rst) begin
         value_mem_q[tail_q]  <= res_value;
         tag_mem_q[tail_q]    <= in_rd_rename;
         taken_mem_q[tail_q]  <= res_taken;
         target_mem_q[tail_q] <= res_target;
      end
   end

   assign alu_broadcast     = (count_q != '0);
   assign alu_full          = fifo_full & ~(alu_broadcast & cdb_grant);
   assign alu_drop          = drop_q;
   assign alu_cbd_value     = alu_broadcast ? value_mem_q[head_q]  : '0;
   assign alu_update_rename = alu_broadcast ? tag_mem_q[head_q]    : '0;
   assign alu_branch_taken  = alu_broadcast ? taken_mem_q[head_q]  : 1'b0;
   assign alu_target_pc     = alu_broadcast ? target_mem_q[head_q] : '0;

endmodule
